// File: rtl/usb_host_xfer_if.sv
// rtl/usb_host_xfer_if.sv - Command, payload, device request/response and completion bundle for usb_host_xfer
interface usb_host_xfer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_pid;
  logic [6:0]  cmd_addr;
  logic [3:0]  cmd_ep;
  logic [15:0] cmd_len;
  logic        cmd_toggle;
  logic [7:0]  wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic        host_pkt_valid;
  logic [3:0]  host_pid;
  logic [6:0]  host_addr;
  logic [3:0]  host_ep;
  logic [15:0] host_data_len;
  logic        host_crc_err;
  logic [7:0]  host_data;
  logic        host_data_valid;
  logic        host_tx_valid;
  logic [3:0]  host_tx_pid;
  logic [7:0]  host_tx_data;
  logic [15:0] host_tx_len;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        done_valid;
  logic [2:0]  done_status;
  logic [15:0] done_count;

  modport master (
    input  cmd_valid, cmd_pid, cmd_addr, cmd_ep, cmd_len, cmd_toggle,
    input  wr_data, wr_valid,
    input  host_tx_valid, host_tx_pid, host_tx_data, host_tx_len,
    output cmd_ready, wr_ready,
    output host_pkt_valid, host_pid, host_addr, host_ep, host_data_len, host_crc_err,
    output host_data, host_data_valid,
    output rd_data, rd_valid,
    output done_valid, done_status, done_count
  );

  modport slave (
    output cmd_valid, cmd_pid, cmd_addr, cmd_ep, cmd_len, cmd_toggle,
    output wr_data, wr_valid,
    output host_tx_valid, host_tx_pid, host_tx_data, host_tx_len,
    input  cmd_ready, wr_ready,
    input  host_pkt_valid, host_pid, host_addr, host_ep, host_data_len, host_crc_err,
    input  host_data, host_data_valid,
    input  rd_data, rd_valid,
    input  done_valid, done_status, done_count
  );
endinterface

// File: rtl/usb_host_xfer.sv
// rtl/usb_host_xfer.sv - Host-side USB transaction initiator: token, data phase, response and handshake
module usb_host_xfer #(
  parameter int unsigned MAX_LEN = 64,
  parameter int unsigned TIMEOUT = 255
) (
  input logic             clk,
  input logic             rst_n,
  usb_host_xfer_if.master bus
);
  localparam logic [3:0] PID_OUT   = 4'h1;
  localparam logic [3:0] PID_IN    = 4'h9;
  localparam logic [3:0] PID_SETUP = 4'hD;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE;

  localparam logic [2:0] ST_ACK     = 3'd0;
  localparam logic [2:0] ST_NAK     = 3'd1;
  localparam logic [2:0] ST_STALL   = 3'd2;
  localparam logic [2:0] ST_TIMEOUT = 3'd3;
  localparam logic [2:0] ST_PROTO   = 3'd4;

  localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);
  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, TOKEN, DHDR, DOUT, WAIT, RXDATA, HSK, DONE} state_e;

  state_e      state_q, state_d;
  logic [3:0]  pid_q, pid_d;
  logic [6:0]  addr_q, addr_d;
  logic [3:0]  ep_q, ep_d;
  logic [15:0] len_q, len_d;
  logic        toggle_q, toggle_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] tmo_q, tmo_d;
  logic [15:0] rxlen_q, rxlen_d;
  logic [2:0]  status_q, status_d;

  logic        cmd_ready_q, cmd_ready_d;
  logic        wr_ready_q, wr_ready_d;
  logic        pkt_valid_q, pkt_valid_d;
  logic [3:0]  hpid_q, hpid_d;
  logic [6:0]  haddr_q, haddr_d;
  logic [3:0]  hep_q, hep_d;
  logic [15:0] hlen_q, hlen_d;
  logic [7:0]  hdata_q, hdata_d;
  logic        hdata_valid_q, hdata_valid_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic        done_valid_q, done_valid_d;
  logic [2:0]  done_status_q, done_status_d;
  logic [15:0] done_count_q, done_count_d;

  logic cmd_pid_ok, is_in, tx_is_data, tx_is_hsk;
  logic [2:0] hsk_status;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign cmd_pid_ok = (bus.cmd_pid == PID_OUT) || (bus.cmd_pid == PID_IN) || (bus.cmd_pid == PID_SETUP);
  assign is_in      = (pid_q == PID_IN);
  assign tx_is_data = (bus.host_tx_pid == PID_DATA0) || (bus.host_tx_pid == PID_DATA1);
  assign tx_is_hsk  = (bus.host_tx_pid == PID_ACK) || (bus.host_tx_pid == PID_NAK) ||
                      (bus.host_tx_pid == PID_STALL);
  assign hsk_status = (bus.host_tx_pid == PID_NAK)   ? ST_NAK :
                      (bus.host_tx_pid == PID_STALL) ? ST_STALL : ST_ACK;

  always_comb begin
    state_d       = state_q;
    pid_d         = pid_q;
    addr_d        = addr_q;
    ep_d          = ep_q;
    len_d         = len_q;
    toggle_d      = toggle_q;
    cnt_d         = cnt_q;
    tmo_d         = tmo_q;
    rxlen_d       = rxlen_q;
    status_d      = status_q;
    pkt_valid_d   = 1'b0;
    hpid_d        = 4'h0;
    haddr_d       = 7'h0;
    hep_d         = 4'h0;
    hlen_d        = 16'h0;
    hdata_d       = 8'h0;
    hdata_valid_d = 1'b0;
    rd_data_d     = 8'h0;
    rd_valid_d    = 1'b0;
    done_valid_d  = 1'b0;
    done_status_d = 3'd0;
    done_count_d  = 16'h0;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          pid_d    = bus.cmd_pid;
          addr_d   = bus.cmd_addr;
          ep_d     = bus.cmd_ep;
          len_d    = bus.cmd_len;
          toggle_d = bus.cmd_toggle;
          cnt_d    = 16'h0;
          tmo_d    = 16'h0;
          rxlen_d  = 16'h0;
          status_d = ST_ACK;
          if (!cmd_pid_ok || (bus.cmd_len > MAX_LEN_W)) begin
            status_d = ST_PROTO;
            state_d  = DONE;
          end else begin
            state_d = TOKEN;
          end
        end
      end
      TOKEN: begin
        pkt_valid_d = 1'b1;
        hpid_d      = pid_q;
        haddr_d     = addr_q;
        hep_d       = ep_q;
        hlen_d      = len_q;
        // The entry cycle of WAIT counts as the first silent cycle.
        tmo_d       = 16'd1;
        state_d     = is_in ? WAIT : DHDR;
      end
      DHDR: begin
        pkt_valid_d = 1'b1;
        hpid_d      = (pid_q == PID_OUT && toggle_q) ? PID_DATA1 : PID_DATA0;
        hlen_d      = len_q;
        tmo_d       = 16'd1;
        state_d     = (len_q == 16'h0) ? WAIT : DOUT;
      end
      DOUT: begin
        if (bus.wr_valid && wr_ready_q) begin
          hdata_d       = bus.wr_data;
          hdata_valid_d = 1'b1;
          cnt_d         = sat_inc(cnt_q);
          if (cnt_d == len_q) begin
            tmo_d   = 16'd1;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        tmo_d = sat_inc(tmo_q);
        if (bus.host_tx_valid) begin
          if (tx_is_hsk) begin
            status_d = hsk_status;
            state_d  = DONE;
          end else if (tx_is_data && is_in) begin
            rxlen_d = bus.host_tx_len;
            if (bus.host_tx_len > len_q) begin
              status_d = ST_PROTO;
              state_d  = DONE;
            end else if (bus.host_tx_len == 16'h0) begin
              state_d = HSK;
            end else begin
              rd_data_d  = bus.host_tx_data;
              rd_valid_d = 1'b1;
              cnt_d      = sat_inc(cnt_q);
              tmo_d      = 16'd1;
              state_d    = (cnt_d == bus.host_tx_len) ? HSK : RXDATA;
            end
          end else begin
            status_d = ST_PROTO;
            state_d  = DONE;
          end
        end else if (tmo_q >= TMO_LAST) begin
          status_d = ST_TIMEOUT;
          state_d  = DONE;
        end
      end
      RXDATA: begin
        tmo_d = sat_inc(tmo_q);
        if (bus.host_tx_valid) begin
          if (tx_is_data) begin
            rd_data_d  = bus.host_tx_data;
            rd_valid_d = 1'b1;
            cnt_d      = sat_inc(cnt_q);
            tmo_d      = 16'd1;
            if (cnt_d == rxlen_q) state_d = HSK;
          end else begin
            status_d = ST_PROTO;
            state_d  = DONE;
          end
        end else if (tmo_q >= TMO_LAST) begin
          status_d = ST_TIMEOUT;
          state_d  = DONE;
        end
      end
      HSK: begin
        pkt_valid_d = 1'b1;
        hpid_d      = PID_ACK;
        status_d    = ST_ACK;
        state_d     = DONE;
      end
      DONE: begin
        done_valid_d  = 1'b1;
        done_status_d = status_q;
        done_count_d  = cnt_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Ready only rises after a full IDLE cycle, which spaces back-to-back commands.
    cmd_ready_d = (state_q == IDLE) && (state_d == IDLE);
    wr_ready_d  = (state_d == DOUT) && (cnt_d < len_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pid_q         <= 4'h0;
      addr_q        <= 7'h0;
      ep_q          <= 4'h0;
      len_q         <= 16'h0;
      toggle_q      <= 1'b0;
      cnt_q         <= 16'h0;
      tmo_q         <= 16'h0;
      rxlen_q       <= 16'h0;
      status_q      <= 3'd0;
      cmd_ready_q   <= 1'b0;
      wr_ready_q    <= 1'b0;
      pkt_valid_q   <= 1'b0;
      hpid_q        <= 4'h0;
      haddr_q       <= 7'h0;
      hep_q         <= 4'h0;
      hlen_q        <= 16'h0;
      hdata_q       <= 8'h0;
      hdata_valid_q <= 1'b0;
      rd_data_q     <= 8'h0;
      rd_valid_q    <= 1'b0;
      done_valid_q  <= 1'b0;
      done_status_q <= 3'd0;
      done_count_q  <= 16'h0;
    end else begin
      state_q       <= state_d;
      pid_q         <= pid_d;
      addr_q        <= addr_d;
      ep_q          <= ep_d;
      len_q         <= len_d;
      toggle_q      <= toggle_d;
      cnt_q         <= cnt_d;
      tmo_q         <= tmo_d;
      rxlen_q       <= rxlen_d;
      status_q      <= status_d;
      cmd_ready_q   <= cmd_ready_d;
      wr_ready_q    <= wr_ready_d;
      pkt_valid_q   <= pkt_valid_d;
      hpid_q        <= hpid_d;
      haddr_q       <= haddr_d;
      hep_q         <= hep_d;
      hlen_q        <= hlen_d;
      hdata_q       <= hdata_d;
      hdata_valid_q <= hdata_valid_d;
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= rd_valid_d;
      done_valid_q  <= done_valid_d;
      done_status_q <= done_status_d;
      done_count_q  <= done_count_d;
    end
  end

  assign bus.cmd_ready       = cmd_ready_q;
  assign bus.wr_ready        = wr_ready_q;
  assign bus.host_pkt_valid  = pkt_valid_q;
  assign bus.host_pid        = hpid_q;
  assign bus.host_addr       = haddr_q;
  assign bus.host_ep         = hep_q;
  assign bus.host_data_len   = hlen_q;
  assign bus.host_crc_err    = 1'b0;
  assign bus.host_data       = hdata_q;
  assign bus.host_data_valid = hdata_valid_q;
  assign bus.rd_data         = rd_data_q;
  assign bus.rd_valid        = rd_valid_q;
  assign bus.done_valid      = done_valid_q;
  assign bus.done_status     = done_status_q;
  assign bus.done_count      = done_count_q;
endmodule
